// File: rtl/hs32_irq_seq_if.sv
// hs32_irq_seq_if: bundles the raw-line, AIC and core-side signals of the interrupt sequencer
interface hs32_irq_seq_if;
  logic [23:0] irq_in;
  logic [23:0] aic_lines;
  logic        aic_intrq;
  logic [4:0]  aic_vec;
  logic [31:0] aic_handler;
  logic        aic_nmi;
  logic        cpu_irq;
  logic [4:0]  cpu_vec;
  logic [31:0] cpu_handler;
  logic        cpu_nmi;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic [23:0] in_service;
  logic [23:0] pending;
  logic        timeout_err;
  modport slave (
    input  irq_in, aic_intrq, aic_vec, aic_handler, aic_nmi, cpu_ack, cpu_eoi,
    output aic_lines, cpu_irq, cpu_vec, cpu_handler, cpu_nmi, in_service, pending, timeout_err
  );
  modport master (
    output irq_in, aic_intrq, aic_vec, aic_handler, aic_nmi, cpu_ack, cpu_eoi,
    input  aic_lines, cpu_irq, cpu_vec, cpu_handler, cpu_nmi, in_service, pending, timeout_err
  );
endinterface

// File: rtl/hs32_irq_seq.sv
// hs32_irq_seq: captures 24 interrupt lines, masks them by nested priority and runs the core handshake
module hs32_irq_seq #(
  parameter logic [23:0] EDGE_MASK   = 24'h000000,
  parameter int          SYNC_STAGES = 2,
  parameter int          ACK_TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset_n,
  hs32_irq_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t                       r_state, w_nxt;
  logic [SYNC_STAGES-1:0][23:0] r_sync;
  logic [23:0]                  r_s_d, r_edge, r_is;
  logic [23:0]                  w_s, w_pend, w_low, w_mask, w_clr;
  logic [4:0]                   r_vec;
  logic [31:0]                  r_handler;
  logic                         r_nmi, r_irq, r_to_err;
  logic [7:0]                   r_cnt, w_cnt_inc;
  logic                         w_load, w_acc, w_to;
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_pend    = (r_edge & EDGE_MASK) | (w_s & ~EDGE_MASK);
  // isolate lowest in-service bit; everything below it may still interrupt
  assign w_low     = r_is & (~r_is + 24'd1);
  assign w_mask    = w_low - 24'd1;
  assign w_clr     = w_acc ? 24'(32'd1 << r_vec) : 24'd0;
  assign w_cnt_inc = r_cnt + 8'd1;
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_acc  = 1'b0;
    w_to   = 1'b0;
    case (r_state)
      IDLE: if (bus.aic_intrq) begin
        w_load = 1'b1;
        w_nxt  = REQ;
      end
      REQ: if (bus.cpu_ack) begin
        w_acc = 1'b1;
        w_nxt = DONE;
      end else if (ACK_TIMEOUT != 0 && w_cnt_inc == 8'(ACK_TIMEOUT)) begin
        w_to  = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_irq   <= w_nxt == REQ;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_s_d     <= '0;
      r_edge    <= '0;
      r_is      <= '0;
      r_vec     <= '0;
      r_handler <= '0;
      r_nmi     <= 1'b0;
      r_to_err  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync[0] <= bus.irq_in;
      for (int j = 1; j < SYNC_STAGES; j++) r_sync[j] <= r_sync[j-1];
      r_s_d    <= w_s;
      r_edge   <= ((r_edge & ~w_clr) | (w_s & ~r_s_d)) & EDGE_MASK;
      r_is     <= (bus.cpu_eoi ? r_is & ~w_low : r_is) | w_clr;
      r_to_err <= r_to_err | w_to;
      r_cnt    <= w_load ? 8'd0 : (r_state == REQ && ACK_TIMEOUT != 0) ? w_cnt_inc : r_cnt;
      if (w_load) begin
        r_vec     <= bus.aic_vec;
        r_handler <= bus.aic_handler;
        r_nmi     <= bus.aic_nmi;
      end
    end
  end
  assign bus.aic_lines   = w_pend & w_mask;
  assign bus.pending     = w_pend;
  assign bus.in_service  = r_is;
  assign bus.cpu_irq     = r_irq;
  assign bus.cpu_vec     = r_vec;
  assign bus.cpu_handler = r_handler;
  assign bus.cpu_nmi     = r_nmi;
  assign bus.timeout_err = r_to_err;
endmodule

// File: tb/tb_hs32_irq_seq.sv
// tb_hs32_irq_seq: directed vectors for the interrupt sequencer with line 7 edge-triggered and a 4-cycle ack timeout
module tb_hs32_irq_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n;
  hs32_irq_seq_if bus();
  hs32_irq_seq #(.EDGE_MASK(24'h000080), .SYNC_STAGES(2), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic req(input logic [4:0] v, input logic [31:0] h, input logic nmi);
    bus.aic_intrq = 1'b1;
    bus.aic_vec = v;
    bus.aic_handler = h;
    bus.aic_nmi = nmi;
    tick();
    bus.aic_intrq = 1'b0;
  endtask
  task automatic ack();
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    tick();
  endtask
  task automatic eoi();
    bus.cpu_eoi = 1'b1;
    tick();
    bus.cpu_eoi = 1'b0;
  endtask
  initial begin
    bus.irq_in = '0;
    bus.aic_intrq = 1'b0;
    bus.aic_vec = '0;
    bus.aic_handler = '0;
    bus.aic_nmi = 1'b0;
    bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b0;
    #12;
    check("rst_irq", 32'(bus.cpu_irq), 32'd0);
    check("rst_is", 32'(bus.in_service), 32'd0);
    check("rst_lines", 32'(bus.aic_lines), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    reset_n = 1'b1;
    tick(2);
    bus.irq_in = 24'h000020;
    tick();
    check("lvl_lat1", 32'(bus.aic_lines), 32'd0);
    tick();
    check("lvl_lat2", 32'(bus.aic_lines), 32'h20);
    req(5'd5, 32'h1000, 1'b0);
    check("lvl_irq", 32'(bus.cpu_irq), 32'd1);
    check("lvl_vec", 32'(bus.cpu_vec), 32'd5);
    check("lvl_hdl", bus.cpu_handler, 32'h1000);
    ack();
    check("lvl_is", 32'(bus.in_service), 32'h20);
    check("lvl_masked", 32'(bus.aic_lines), 32'd0);
    check("lvl_irq_lo", 32'(bus.cpu_irq), 32'd0);
    eoi();
    check("lvl_eoi_is", 32'(bus.in_service), 32'd0);
    check("lvl_eoi_lines", 32'(bus.aic_lines), 32'h20);
    bus.irq_in = '0;
    tick(2);
    bus.irq_in = 24'h000200;
    tick(2);
    req(5'd9, 32'h900, 1'b0);
    ack();
    check("nest_is9", 32'(bus.in_service), 32'h200);
    bus.irq_in = 24'h001000;
    tick(2);
    check("nest_12_pend", 32'(bus.pending), 32'h1000);
    check("nest_12_masked", 32'(bus.aic_lines), 32'd0);
    bus.irq_in = 24'h001008;
    tick(2);
    check("nest_3_pass", 32'(bus.aic_lines), 32'h8);
    req(5'd3, 32'h300, 1'b0);
    check("nest_vec3", 32'(bus.cpu_vec), 32'd3);
    ack();
    check("nest_is208", 32'(bus.in_service), 32'h208);
    bus.irq_in = 24'h001000;
    tick(2);
    eoi();
    check("nest_eoi1", 32'(bus.in_service), 32'h200);
    check("nest_eoi1_lines", 32'(bus.aic_lines), 32'd0);
    eoi();
    check("nest_eoi2", 32'(bus.in_service), 32'd0);
    check("nest_eoi2_lines", 32'(bus.aic_lines), 32'h1000);
    req(5'd12, 32'hC00, 1'b0);
    check("nest_vec12", 32'(bus.cpu_vec), 32'd12);
    ack();
    check("nest_is12", 32'(bus.in_service), 32'h1000);
    eoi();
    bus.irq_in = '0;
    tick(2);
    bus.irq_in = 24'h000080;
    tick();
    bus.irq_in = '0;
    tick(2);
    check("edge_set", 32'(bus.pending), 32'h80);
    tick(3);
    check("edge_sticky", 32'(bus.pending), 32'h80);
    check("edge_lines", 32'(bus.aic_lines), 32'h80);
    req(5'd7, 32'h700, 1'b1);
    check("edge_nmi", 32'(bus.cpu_nmi), 32'd1);
    ack();
    check("edge_clr", 32'(bus.pending), 32'd0);
    check("edge_is", 32'(bus.in_service), 32'h80);
    eoi();
    bus.irq_in = 24'h000080;
    tick();
    bus.irq_in = '0;
    tick(2);
    req(5'd7, 32'h700, 1'b0);
    bus.irq_in = 24'h000080;
    tick();
    bus.irq_in = '0;
    tick();
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    check("edge_set_wins", 32'(bus.pending), 32'h80);
    check("edge_is2", 32'(bus.in_service), 32'h80);
    tick();
    eoi();
    req(5'd7, 32'h700, 1'b0);
    ack();
    check("edge_clr2", 32'(bus.pending), 32'd0);
    eoi();
    bus.irq_in = 24'h000002;
    tick(2);
    req(5'd1, 32'h2000, 1'b0);
    n = 0;
    while (bus.cpu_irq && n < 20) begin
      n++;
      tick();
    end
    check("to_cycles", 32'(n), 32'd4);
    check("to_err", 32'(bus.timeout_err), 32'd1);
    check("to_pend", 32'(bus.pending), 32'h2);
    check("to_is", 32'(bus.in_service), 32'd0);
    req(5'd1, 32'h2000, 1'b0);
    check("to_reissue", 32'(bus.cpu_irq), 32'd1);
    ack();
    check("to_is1", 32'(bus.in_service), 32'h2);
    eoi();
    bus.irq_in = '0;
    tick(2);
    req(5'd4, 32'h400, 1'b0);
    ack();
    check("both_is10", 32'(bus.in_service), 32'h10);
    req(5'd2, 32'h200, 1'b0);
    bus.cpu_ack = 1'b1;
    bus.cpu_eoi = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b0;
    check("both_is4", 32'(bus.in_service), 32'h4);
    tick();
    bus.irq_in = 24'h000002;
    tick(2);
    check("arst_lines", 32'(bus.aic_lines), 32'h2);
    req(5'd1, 32'h100, 1'b0);
    check("arst_irq_pre", 32'(bus.cpu_irq), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_irq", 32'(bus.cpu_irq), 32'd0);
    check("arst_is", 32'(bus.in_service), 32'd0);
    check("arst_pend", 32'(bus.pending), 32'd0);
    check("arst_terr", 32'(bus.timeout_err), 32'd0);
    check("arst_vec", 32'(bus.cpu_vec), 32'd0);
    bus.irq_in = '0;
    #3;
    reset_n = 1'b1;
    tick(2);
    check("arst_idle", 32'(bus.cpu_irq), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
